// File: rtl/dm_store_buffer.sv
// MEM-stage store buffer in front of the data memory: in-order store FIFO, load priority with word-alias stalls.
// Optional store-to-load word forwarding is compiled in with `define SB_FWD_EN.
module dm_store_buffer #(
  parameter int             DEPTH     = 4,
  parameter int             PTR_W     = 2,
  parameter logic [2:0]     LST_WORD  = 3'b010
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             St_valid,
  input  logic [31:0]      St_addr,
  input  logic [31:0]      St_data,
  input  logic [2:0]       St_type,
  output logic             St_ready,
  input  logic             Ld_valid,
  input  logic [31:0]      Ld_addr,
  input  logic [2:0]       Ld_type,
  output logic             Ld_stall,
  output logic             Ld_fwd_hit,
  output logic [31:0]      Ld_fwd_data,
  output logic             DMWr,
  output logic [31:0]      DMAddr,
  output logic [31:0]      DIN,
  output logic [2:0]       L_S_SL,
  output logic [PTR_W:0]   Count
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [2:0]       type_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W:0]   count_q;

  logic [DEPTH-1:0] alias_vec;
  logic             any_alias;
  logic             fwd_hit;
  logic             load_owns;
  logic             enq;
  logic             drain;

  // Ready looks only at the registered count, so a same-cycle drain never makes room.
  assign St_ready = (count_q != CNT_FULL);
  assign enq      = St_valid && St_ready;
  assign Count    = count_q;

  // NOTE: every signal written in an always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    alias_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      alias_vec[i] = valid_q[i] && (addr_q[i][11:2] == Ld_addr[11:2]);
    end
  end

  assign any_alias = |alias_vec;

`ifdef SB_FWD_EN
  logic [PTR_W-1:0] scan_idx;
  logic             young_is_word;
  logic [31:0]      young_data;

  // Scan from head (oldest) towards tail so the last match is the youngest aliasing store.
  always_comb begin
    scan_idx      = head_q;
    young_is_word = 1'b0;
    young_data    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PTR_W'(i);
      if (alias_vec[scan_idx]) begin
        young_is_word = (type_q[scan_idx] == LST_WORD);
        young_data    = data_q[scan_idx];
      end
    end
  end

  assign fwd_hit     = Ld_valid && any_alias && (Ld_type == LST_WORD) && young_is_word;
  assign Ld_fwd_data = fwd_hit ? young_data : '0;
`else
  assign fwd_hit     = 1'b0;
  assign Ld_fwd_data = '0;
`endif

  assign Ld_fwd_hit = fwd_hit;
  assign Ld_stall   = Ld_valid && any_alias && !fwd_hit;

  // A forwarded load does not need DM, so the port is free to drain in that cycle.
  assign load_owns = Ld_valid && !Ld_stall && !fwd_hit;
  assign drain     = !load_owns && (count_q != '0);

  always_comb begin
    DMWr   = 1'b0;
    DMAddr = '0;
    DIN    = '0;
    L_S_SL = '0;
    if (load_owns) begin
      DMAddr = Ld_addr;
      L_S_SL = Ld_type;
    end else if (drain) begin
      DMWr   = 1'b1;
      DMAddr = addr_q[head_q];
      DIN    = data_q[head_q];
      L_S_SL = type_q[head_q];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // Enqueue and drain never target the same slot: that needs full (no enqueue) or empty (no drain).
      if (enq) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_ONE;
      end
      if (drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_ONE;
      end
      case ({enq, drain})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: payload storage is not reset; the valid bits and count alone decide what is live.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= St_addr;
      data_q[tail_q] <= St_data;
      type_q[tail_q] <= St_type;
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Self-checking bench for dm_store_buffer: per-scenario tasks plus a DM-write scoreboard.
module tb_dm_store_buffer;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam logic [2:0] T_B = 3'b000;
  localparam logic [2:0] T_H = 3'b001;
  localparam logic [2:0] T_W = 3'b010;
`ifdef SB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk;
  logic             Reset_n;
  logic             St_valid;
  logic [31:0]      St_addr;
  logic [31:0]      St_data;
  logic [2:0]       St_type;
  logic             St_ready;
  logic             Ld_valid;
  logic [31:0]      Ld_addr;
  logic [2:0]       Ld_type;
  logic             Ld_stall;
  logic             Ld_fwd_hit;
  logic [31:0]      Ld_fwd_data;
  logic             DMWr;
  logic [31:0]      DMAddr;
  logic [31:0]      DIN;
  logic [2:0]       L_S_SL;
  logic [PTR_W:0]   Count;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  typ;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  errors = 0;
  int  checks = 0;

  dm_store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .Reset_n(Reset_n),
    .St_valid(St_valid), .St_addr(St_addr), .St_data(St_data), .St_type(St_type), .St_ready(St_ready),
    .Ld_valid(Ld_valid), .Ld_addr(Ld_addr), .Ld_type(Ld_type), .Ld_stall(Ld_stall),
    .Ld_fwd_hit(Ld_fwd_hit), .Ld_fwd_data(Ld_fwd_data),
    .DMWr(DMWr), .DMAddr(DMAddr), .DIN(DIN), .L_S_SL(L_S_SL), .Count(Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every DM write must match the oldest accepted store still outstanding.
  always @(negedge clk) begin
    if (DMWr === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dm_write_unexpected: got addr=%h data=%h type=%0d, expected no write", DMAddr, DIN, L_S_SL);
      end else begin
        mon_e = exp_q.pop_front();
        if ({DMAddr, DIN, L_S_SL} !== {mon_e.addr, mon_e.data, mon_e.typ}) begin
          errors++;
          $display("FAIL dm_write_order: got addr=%h data=%h type=%0d, expected addr=%h data=%h type=%0d",
                   DMAddr, DIN, L_S_SL, mon_e.addr, mon_e.data, mon_e.typ);
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    St_valid = 1'b1;
    St_addr  = a;
    St_data  = d;
    St_type  = t;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.typ  = t;
    exp_q.push_back(e);
  endtask

  task automatic hold_port();
    Ld_valid = 1'b1;
    Ld_addr  = 32'h0000_0800;
    Ld_type  = T_W;
  endtask

  task automatic wait_empty();
    int n = 0;
    St_valid = 1'b0;
    Ld_valid = 1'b0;
    while (Count !== '0 && n < 20) begin
      nxt();
      n++;
    end
    checks++;
    if (Count !== '0) begin
      errors++;
      $display("FAIL drain_timeout: Count=%0d after %0d cycles, expected 0", Count, n);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d writes outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    St_valid = 1'b0; St_addr = '0; St_data = '0; St_type = '0;
    Ld_valid = 1'b0; Ld_addr = '0; Ld_type = '0;
    #1;
    checks++; if (Count !== 3'd0)    begin errors++; $display("FAIL reset_count: got %0d want 0", Count); end
    checks++; if (DMWr !== 1'b0)     begin errors++; $display("FAIL reset_dmwr: got %b want 0", DMWr); end
    checks++; if (St_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", St_ready); end
    checks++; if (Ld_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", Ld_stall); end
    checks++; if (Ld_fwd_hit !== 1'b0) begin errors++; $display("FAIL reset_fwd: got %b want 0", Ld_fwd_hit); end
    #1 Reset_n = 1'b1;
    nxt();
  endtask

  task automatic test_single_store();
    drive_store(32'h10, 32'hDEAD_BEEF, T_W);
    mid();
    checks++; if (St_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", St_ready); end
    checks++; if (DMWr !== 1'b0) begin errors++; $display("FAIL single_no_passthru: got %b want 0", DMWr); end
    push_exp(32'h10, 32'hDEAD_BEEF, T_W);
    nxt();
    St_valid = 1'b0;
    mid();
    checks++; if ({DMWr, DMAddr, DIN} !== {1'b1, 32'h10, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL single_drain: got wr=%b addr=%h din=%h want 1 00000010 deadbeef", DMWr, DMAddr, DIN);
    end
    checks++; if (Count !== 3'd1) begin errors++; $display("FAIL single_count1: got %0d want 1", Count); end
    nxt();
    mid();
    checks++; if (Count !== 3'd0 || DMWr !== 1'b0) begin
      errors++; $display("FAIL single_empty: got count=%0d wr=%b want 0 0", Count, DMWr);
    end
    nxt();
  endtask

  task automatic test_back_to_back();
    logic [2:0]  t;
    logic [31:0] d;
    for (int i = 0; i < 5; i++) begin
      t = (i % 3 == 0) ? T_W : ((i % 3 == 1) ? T_H : T_B);
      d = $urandom;
      drive_store(32'h100 + 32'(4 * i), d, t);
      mid();
      checks++; if (St_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, St_ready); end
      if (i > 0) begin
        checks++; if (Count !== 3'd1) begin errors++; $display("FAIL b2b_count[%0d]: got %0d want 1", i, Count); end
      end
      push_exp(32'h100 + 32'(4 * i), d, t);
      nxt();
    end
    wait_empty();
  endtask

  task automatic test_async_reset();
    hold_port();
    for (int i = 0; i < 3; i++) begin
      drive_store(32'h200 + 32'(4 * i), $urandom, T_W);
      nxt();
    end
    St_valid = 1'b0;
    mid();
    checks++; if (Count !== 3'd3) begin errors++; $display("FAIL areset_prefill: got %0d want 3", Count); end
    #1 Ld_valid = 1'b0;
    #1 Reset_n = 1'b0;
    #1;
    checks++; if (Count !== 3'd0) begin errors++; $display("FAIL areset_count: got %0d want 0", Count); end
    checks++; if (DMWr !== 1'b0)  begin errors++; $display("FAIL areset_dmwr: got %b want 0", DMWr); end
    checks++; if (St_ready !== 1'b1) begin errors++; $display("FAIL areset_ready: got %b want 1", St_ready); end
    @(posedge clk);
    #2 Reset_n = 1'b1;
    nxt();
    mid();
    checks++; if (Count !== 3'd0 || DMWr !== 1'b0) begin
      errors++; $display("FAIL areset_after: got count=%0d wr=%b want 0 0", Count, DMWr);
    end
    nxt();
  endtask

  task automatic test_load_priority();
    logic [31:0] d0, d1;
    d0 = $urandom;
    d1 = $urandom;
    Ld_valid = 1'b1; Ld_addr = 32'h104; Ld_type = T_W;
    drive_store(32'h20, d0, T_W);
    mid();
    checks++; if ({DMWr, DMAddr, L_S_SL, Ld_stall} !== {1'b0, 32'h104, T_W, 1'b0}) begin
      errors++; $display("FAIL ldpri_owns: got wr=%b addr=%h type=%0d stall=%b want 0 00000104 2 0", DMWr, DMAddr, L_S_SL, Ld_stall);
    end
    push_exp(32'h20, d0, T_W);
    nxt();
    drive_store(32'h24, d1, T_W);
    mid();
    checks++; if (DMWr !== 1'b0 || Count !== 3'd1) begin
      errors++; $display("FAIL ldpri_pause1: got wr=%b count=%0d want 0 1", DMWr, Count);
    end
    push_exp(32'h24, d1, T_W);
    nxt();
    St_valid = 1'b0;
    mid();
    checks++; if (DMWr !== 1'b0 || Count !== 3'd2) begin
      errors++; $display("FAIL ldpri_pause2: got wr=%b count=%0d want 0 2", DMWr, Count);
    end
    nxt();
    Ld_addr = 32'h26; Ld_type = T_H;
    mid();
    checks++; if (Ld_stall !== 1'b1 || DMWr !== 1'b1) begin
      errors++; $display("FAIL ldpri_stall1: got stall=%b wr=%b want 1 1", Ld_stall, DMWr);
    end
    nxt();
    mid();
    checks++; if (Ld_stall !== 1'b1 || Count !== 3'd1) begin
      errors++; $display("FAIL ldpri_stall2: got stall=%b count=%0d want 1 1", Ld_stall, Count);
    end
    nxt();
    mid();
    checks++; if ({Ld_stall, DMWr, DMAddr, L_S_SL} !== {1'b0, 1'b0, 32'h26, T_H}) begin
      errors++; $display("FAIL ldpri_release: got stall=%b wr=%b addr=%h type=%0d want 0 0 00000026 1", Ld_stall, DMWr, DMAddr, L_S_SL);
    end
    nxt();
    wait_empty();
  endtask

  task automatic test_same_cycle();
    logic [31:0] d;
    d = $urandom;
    Ld_valid = 1'b1; Ld_addr = 32'h50; Ld_type = T_W;
    drive_store(32'h50, d, T_W);
    mid();
    checks++; if ({Ld_stall, DMWr, DMAddr, St_ready} !== {1'b0, 1'b0, 32'h50, 1'b1}) begin
      errors++; $display("FAIL same_cycle_enter: got stall=%b wr=%b addr=%h rdy=%b want 0 0 00000050 1", Ld_stall, DMWr, DMAddr, St_ready);
    end
    push_exp(32'h50, d, T_W);
    nxt();
    St_valid = 1'b0;
    mid();
    checks++; if ({Ld_stall, Ld_fwd_hit, DMWr} !== {!FWD, FWD, 1'b1}) begin
      errors++; $display("FAIL same_cycle_alias: got stall=%b fwd=%b wr=%b want %b %b 1", Ld_stall, Ld_fwd_hit, DMWr, !FWD, FWD);
    end
    nxt();
    mid();
    checks++; if ({Ld_stall, DMWr, Count} !== {1'b0, 1'b0, 3'd0}) begin
      errors++; $display("FAIL same_cycle_done: got stall=%b wr=%b count=%0d want 0 0 0", Ld_stall, DMWr, Count);
    end
    nxt();
    wait_empty();
  endtask

  task automatic test_full_wrap();
    logic [31:0] d;
    logic [2:0]  t;
    hold_port();
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      drive_store(32'h300 + 32'(4 * i), d, T_W);
      mid();
      checks++; if (St_ready !== 1'b1) begin errors++; $display("FAIL full_ready[%0d]: got %b want 1", i, St_ready); end
      push_exp(32'h300 + 32'(4 * i), d, T_W);
      nxt();
    end
    d = $urandom;
    drive_store(32'h310, d, T_H);
    mid();
    checks++; if ({St_ready, Count, DMWr} !== {1'b0, 3'd4, 1'b0}) begin
      errors++; $display("FAIL full_blocked: got rdy=%b count=%0d wr=%b want 0 4 0", St_ready, Count, DMWr);
    end
    nxt();
    Ld_valid = 1'b0;
    mid();
    checks++; if (St_ready !== 1'b0 || DMWr !== 1'b1) begin
      errors++; $display("FAIL full_first_drain: got rdy=%b wr=%b want 0 1", St_ready, DMWr);
    end
    nxt();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        d = $urandom;
        t = (k % 2 == 0) ? T_W : T_B;
        drive_store(32'h310 + 32'(4 * k), d, t);
      end else begin
        t = T_H;
      end
      mid();
      checks++; if (St_ready !== 1'b1 || Count !== 3'(DEPTH - 1)) begin
        errors++; $display("FAIL wrap_steady[%0d]: got rdy=%b count=%0d want 1 %0d", k, St_ready, Count, DEPTH - 1);
      end
      push_exp(32'h310 + 32'(4 * k), d, t);
      nxt();
    end
    wait_empty();
  endtask

  task automatic test_forward();
    logic [31:0] z;
    // Word store then word load: forwarded when enabled, stalled otherwise.
    hold_port();
    drive_store(32'h40, 32'h1234_5678, T_W);
    push_exp(32'h40, 32'h1234_5678, T_W);
    nxt();
    St_valid = 1'b0; Ld_addr = 32'h40; Ld_type = T_W;
    mid();
    checks++; if ({Ld_fwd_hit, Ld_fwd_data, Ld_stall, DMWr} !== {FWD, (FWD ? 32'h1234_5678 : 32'h0), !FWD, 1'b1}) begin
      errors++; $display("FAIL fwd_word: got hit=%b data=%h stall=%b wr=%b want %b %h %b 1",
                         Ld_fwd_hit, Ld_fwd_data, Ld_stall, DMWr, FWD, (FWD ? 32'h1234_5678 : 32'h0), !FWD);
    end
    nxt();
    mid();
    checks++; if ({Ld_stall, Ld_fwd_hit, DMWr, DMAddr} !== {1'b0, 1'b0, 1'b0, 32'h40}) begin
      errors++; $display("FAIL fwd_word_after: got stall=%b hit=%b wr=%b addr=%h want 0 0 0 00000040", Ld_stall, Ld_fwd_hit, DMWr, DMAddr);
    end
    nxt();
    // Byte load against a word store always stalls.
    hold_port();
    drive_store(32'h40, 32'hA5A5_5A5A, T_W);
    push_exp(32'h40, 32'hA5A5_5A5A, T_W);
    nxt();
    St_valid = 1'b0; Ld_addr = 32'h41; Ld_type = T_B;
    mid();
    checks++; if (Ld_stall !== 1'b1 || Ld_fwd_hit !== 1'b0) begin
      errors++; $display("FAIL fwd_byte_stall: got stall=%b hit=%b want 1 0", Ld_stall, Ld_fwd_hit);
    end
    nxt();
    mid();
    checks++; if (Ld_stall !== 1'b0 || DMAddr !== 32'h41) begin
      errors++; $display("FAIL fwd_byte_release: got stall=%b addr=%h want 0 00000041", Ld_stall, DMAddr);
    end
    nxt();
    // Youngest aliasing store is a halfword: stall even with forwarding.
    hold_port();
    drive_store(32'h40, $urandom, T_W);
    push_exp(St_addr, St_data, T_W);
    nxt();
    drive_store(32'h42, $urandom, T_H);
    push_exp(St_addr, St_data, T_H);
    nxt();
    St_valid = 1'b0; Ld_addr = 32'h40; Ld_type = T_W;
    mid();
    checks++; if (Ld_stall !== 1'b1 || Ld_fwd_hit !== 1'b0) begin
      errors++; $display("FAIL fwd_young_half: got stall=%b hit=%b want 1 0", Ld_stall, Ld_fwd_hit);
    end
    nxt();
    mid();
    checks++; if (Ld_stall !== 1'b1) begin errors++; $display("FAIL fwd_young_half2: got stall=%b want 1", Ld_stall); end
    nxt();
    mid();
    checks++; if (Ld_stall !== 1'b0) begin errors++; $display("FAIL fwd_young_half3: got stall=%b want 0", Ld_stall); end
    nxt();
    // Older halfword, younger word: the younger word's data is forwarded.
    z = $urandom;
    hold_port();
    drive_store(32'h40, $urandom, T_H);
    push_exp(St_addr, St_data, T_H);
    nxt();
    drive_store(32'h40, z, T_W);
    push_exp(32'h40, z, T_W);
    nxt();
    St_valid = 1'b0; Ld_addr = 32'h40; Ld_type = T_W;
    mid();
    checks++; if ({Ld_fwd_hit, Ld_fwd_data, Ld_stall, DMWr} !== {FWD, (FWD ? z : 32'h0), !FWD, 1'b1}) begin
      errors++; $display("FAIL fwd_young_word: got hit=%b data=%h stall=%b wr=%b want %b %h %b 1",
                         Ld_fwd_hit, Ld_fwd_data, Ld_stall, DMWr, FWD, (FWD ? z : 32'h0), !FWD);
    end
    nxt();
    wait_empty();
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_back_to_back();
    test_async_reset();
    test_load_priority();
    test_same_cycle();
    test_full_wrap();
    test_forward();
    repeat (2) nxt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
